// File: rtl/uop_pkg.sv
// uop_pkg: definitions shared by the micro-op sequencer.
//   - Macro opcodes that expand into several micro-ops (OP_CALL, OP_RET, OP_RTI).
//   - First micro-opcode of the interrupt-entry sequence (OP_INT0).
//   - Sequencer state enum and the parts_of() lookup for macro expansion.
package uop_pkg;

  localparam int PKG_OPC_W = 5;

  localparam logic [PKG_OPC_W-1:0] OP_CALL = 5'b11000;
  localparam logic [PKG_OPC_W-1:0] OP_RET  = 5'b11010;
  localparam logic [PKG_OPC_W-1:0] OP_RTI  = 5'b11100;
  localparam logic [PKG_OPC_W-1:0] OP_INT0 = 5'b11110;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    SEQ   = 2'd1,
    INT   = 2'd2
  } uop_state_e;

  // Number of micro-ops a macro instruction expands into.
  function automatic int unsigned parts_of(input logic [PKG_OPC_W-1:0] opc);
    case (opc)
      OP_CALL, OP_RET, OP_RTI: return 2;
      default:                 return 1;
    endcase
  endfunction

endpackage

// File: rtl/uop_sequencer_int_pending.sv
// uop_int_pending: interrupt pending latch, optional nesting mask and the
// int_ack pulse.
//   Config macro: UOP_SEQ_INT_MASK_EN (when defined, a pending interrupt is
//   held off while in_isr_i is set, so interrupts do not nest).
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   stall_i      freeze int_ack; pending can still be latched
//   intr_req_i   interrupt request (level or pulse)
//   slot_i       sequencer is at an instruction boundary (ISSUE, no flush)
//   in_isr_i     sequencer is inside an interrupt service routine
//   take_o       combinational: interrupt entry starts on this edge
//   int_ack_o    registered one-cycle pulse aligned with the first INT micro-op
module uop_int_pending (
  input  logic clk,
  input  logic rst_n,
  input  logic stall_i,
  input  logic intr_req_i,
  input  logic slot_i,
  input  logic in_isr_i,
  output logic take_o,
  output logic int_ack_o
);

  logic pending_q;
  logic int_ack_q;
  logic masked;

`ifdef UOP_SEQ_INT_MASK_EN
  assign masked = in_isr_i;
`else
  // in_isr is status only here; interrupts nest.
  assign masked = in_isr_i & 1'b0;
`endif

  assign take_o    = pending_q & slot_i & ~stall_i & ~masked;
  assign int_ack_o = int_ack_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_q <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      if (!stall_i) int_ack_q <= take_o;
      // A request arriving on the take edge merges with the one being taken.
      if (take_o)          pending_q <= 1'b0;
      else if (intr_req_i) pending_q <= 1'b1;
    end
  end

endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: registered front end to the instruction decoder. Expands
// CALL/RET/RTI into consecutive micro-ops and injects an interrupt-entry
// sequence at instruction boundaries.
//   Config macro: UOP_SEQ_INT_MASK_EN (non-nesting interrupts, see
//   uop_int_pending).
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   instr_valid, instr_opcode  instruction from the decode latch
//   stall_in                   freeze all state and outputs
//   flush                      squash the current issue slot
//   intr_req                   interrupt request
//   uop_valid, uop_opcode      micro-op to the decoder (1-cycle latency)
//   uop_bubble                 decoder bubble, always !uop_valid
//   fetch_hold                 fetch/PC must not advance next cycle
//   int_ack                    pulse when interrupt entry starts
//   in_isr                     set on interrupt entry, cleared on RTI part 0
module uop_sequencer
  import uop_pkg::*;
#(
  parameter int               OPC_W     = 5,
  parameter int               MAX_PARTS = 2,
  parameter int               INT_PARTS = 2,
  parameter logic [OPC_W-1:0] INT_BASE  = OP_INT0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  input  logic [OPC_W-1:0] instr_opcode,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             intr_req,
  output logic             uop_valid,
  output logic [OPC_W-1:0] uop_opcode,
  output logic             uop_bubble,
  output logic             fetch_hold,
  output logic             int_ack,
  output logic             in_isr
);

  localparam int              PC_W      = $clog2(MAX_PARTS + 1);
  localparam logic [PC_W-1:0] ONE       = PC_W'(1);
  localparam logic [PC_W-1:0] INT_N     = PC_W'(INT_PARTS);
  localparam bit              INT_MULTI = (INT_PARTS > 1);

  uop_state_e       state_q, state_d;
  logic [PC_W-1:0]  part_cnt_q, part_cnt_d;
  logic [OPC_W-1:0] base_q, base_d;
  logic             uop_valid_q, uop_valid_d;
  logic             uop_bubble_q, uop_bubble_d;
  logic [OPC_W-1:0] uop_opcode_q, uop_opcode_d;
  logic             fetch_hold_q, fetch_hold_d;
  logic             in_isr_q, in_isr_d;

  logic [PC_W-1:0]  instr_parts, seq_parts, part_cnt_inc;
  logic             seq_last, int_last, take, int_ack_w;

  assign instr_parts  = PC_W'(parts_of(instr_opcode));
  assign seq_parts    = PC_W'(parts_of(base_q));
  assign part_cnt_inc = part_cnt_q + ONE;
  assign seq_last     = (part_cnt_inc == seq_parts);
  assign int_last     = (part_cnt_inc == INT_N);

  uop_int_pending u_int_pending (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall_i    (stall_in),
    .intr_req_i (intr_req),
    .slot_i     ((state_q == ISSUE) && !flush),
    .in_isr_i   (in_isr_q),
    .take_o     (take),
    .int_ack_o  (int_ack_w)
  );

  // State register (all outputs are registered here too).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ISSUE;
      part_cnt_q   <= '0;
      base_q       <= '0;
      uop_valid_q  <= 1'b0;
      uop_bubble_q <= 1'b1;
      uop_opcode_q <= '0;
      fetch_hold_q <= 1'b0;
      in_isr_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      part_cnt_q   <= part_cnt_d;
      base_q       <= base_d;
      uop_valid_q  <= uop_valid_d;
      uop_bubble_q <= uop_bubble_d;
      uop_opcode_q <= uop_opcode_d;
      fetch_hold_q <= fetch_hold_d;
      in_isr_q     <= in_isr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    part_cnt_d = part_cnt_q;
    base_d     = base_q;
    if (!stall_in) begin
      case (state_q)
        ISSUE: begin
          if (flush) begin
            // squashed slot, stay
          end else if (take) begin
            if (INT_MULTI) begin
              state_d    = INT;
              part_cnt_d = ONE;
            end
          end else if (instr_valid && (instr_parts > ONE)) begin
            state_d    = SEQ;
            part_cnt_d = ONE;
            base_d     = instr_opcode;
          end
        end
        SEQ: begin
          if (flush || seq_last) begin
            state_d    = ISSUE;
            part_cnt_d = '0;
          end else begin
            part_cnt_d = part_cnt_inc;
          end
        end
        INT: begin
          // Interrupt entry is atomic: flush is not looked at.
          if (int_last) begin
            state_d    = ISSUE;
            part_cnt_d = '0;
          end else begin
            part_cnt_d = part_cnt_inc;
          end
        end
        default: begin
          state_d    = ISSUE;
          part_cnt_d = '0;
        end
      endcase
    end
  end

  // Output logic (next values of the registered outputs).
  always_comb begin
    uop_valid_d  = uop_valid_q;
    uop_opcode_d = uop_opcode_q;
    fetch_hold_d = fetch_hold_q;
    in_isr_d     = in_isr_q;
    if (!stall_in) begin
      uop_valid_d  = 1'b0;
      uop_opcode_d = '0;
      fetch_hold_d = 1'b0;
      case (state_q)
        ISSUE: begin
          if (flush) begin
            // bubble
          end else if (take) begin
            uop_valid_d  = 1'b1;
            uop_opcode_d = INT_BASE;
            fetch_hold_d = INT_MULTI;
            in_isr_d     = 1'b1;
          end else if (instr_valid) begin
            uop_valid_d  = 1'b1;
            uop_opcode_d = instr_opcode;
            fetch_hold_d = (instr_parts > ONE);
            if (instr_opcode == OP_RTI) in_isr_d = 1'b0;
          end
        end
        SEQ: begin
          if (!flush) begin
            uop_valid_d  = 1'b1;
            uop_opcode_d = base_q + OPC_W'(part_cnt_q);
            fetch_hold_d = !seq_last;
          end
        end
        INT: begin
          uop_valid_d  = 1'b1;
          uop_opcode_d = INT_BASE + OPC_W'(part_cnt_q);
          fetch_hold_d = !int_last;
        end
        default: ;
      endcase
    end
    uop_bubble_d = !uop_valid_d;
  end

  assign uop_valid  = uop_valid_q;
  assign uop_opcode = uop_opcode_q;
  assign uop_bubble = uop_bubble_q;
  assign fetch_hold = fetch_hold_q;
  assign int_ack    = int_ack_w;
  assign in_isr     = in_isr_q;

endmodule
